// File: rtl/pc_seq_pkg.sv
// Shared types and default vectors for the PC sequencer slice.
// Optional misaligned-target trapping is enabled by defining PC_SEQ_MISALIGN_TRAP_EN.
package pc_seq_pkg;

  localparam int unsigned DefaultXlen       = 64;
  localparam int unsigned DefaultInstrBytes = 4;
  localparam logic [63:0] DefaultResetVec   = 64'h0;
  localparam logic [63:0] DefaultTrapVec    = 64'h100;

  typedef enum logic [1:0] {
    StBoot,
    StRun,
    StHalt
  } state_e;

  typedef enum logic [1:0] {
    SrcNone,
    SrcBranch,
    SrcJump,
    SrcTrap
  } redir_src_e;

  function automatic logic is_misaligned(input logic [1:0] lsbs);
    return lsbs != 2'b00;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Signal bundle between the PC sequencer and its redirect sources, PC register and fetch.
// The misalign signal exists only when PC_SEQ_MISALIGN_TRAP_EN is defined.
interface pc_sequencer_if #(
  parameter int unsigned XLEN = pc_seq_pkg::DefaultXlen
);
  logic [XLEN-1:0] pc_cur;
  logic [XLEN-1:0] pc_next;
  logic            fetch_req;
  logic            fetch_ready;
  logic            stall;
  logic            jump;
  logic [XLEN-1:0] jump_target;
  logic            branch_taken;
  logic [XLEN-1:0] branch_target;
  logic            trap;
  logic            halt;
  logic            redirect_pending;
  logic            halted;
  logic            trap_taken;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
  logic            misalign;
`endif

  modport master (
    input  pc_cur, fetch_ready, stall, jump, jump_target, branch_taken, branch_target,
    input  trap, halt,
    output pc_next, fetch_req, redirect_pending, halted, trap_taken
`ifdef PC_SEQ_MISALIGN_TRAP_EN
    , output misalign
`endif
  );

  modport slave (
    output pc_cur, fetch_ready, stall, jump, jump_target, branch_taken, branch_target,
    output trap, halt,
    input  pc_next, fetch_req, redirect_pending, halted, trap_taken
`ifdef PC_SEQ_MISALIGN_TRAP_EN
    , input misalign
`endif
  );

endinterface

// File: rtl/pc_redirect_buf.sv
// Single-entry pending-redirect register: the first redirect is kept, only a trap may replace it.
// Tracks the misalign origin of a pending trap when PC_SEQ_MISALIGN_TRAP_EN is defined.
module pc_redirect_buf
  import pc_seq_pkg::*;
#(
  parameter int unsigned XLEN = DefaultXlen
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            clear_i,
  input  logic            capture_i,
  input  redir_src_e      redir_src_i,
  input  logic [XLEN-1:0] redir_addr_i,
`ifdef PC_SEQ_MISALIGN_TRAP_EN
  input  logic            redir_mis_i,
  output logic            pend_mis_o,
`endif
  output logic            pend_valid_o,
  output logic            pend_trap_o,
  output logic [XLEN-1:0] pend_addr_o
);

  logic            valid_q, valid_d;
  redir_src_e      src_q, src_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            load;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
  logic            mis_q, mis_d;
`endif

  // A pending jump/branch shadows later ones; a trap always replaces the entry.
  assign load = capture_i && (redir_src_i != SrcNone) &&
                (!valid_q || (redir_src_i == SrcTrap));

  always_comb begin
    valid_d = valid_q;
    src_d   = src_q;
    addr_d  = addr_q;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
    mis_d   = mis_q;
`endif
    if (clear_i) begin
      valid_d = 1'b0;
      src_d   = SrcNone;
      addr_d  = '0;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
      mis_d   = 1'b0;
`endif
    end else if (load) begin
      valid_d = 1'b1;
      src_d   = redir_src_i;
      addr_d  = redir_addr_i;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
      mis_d   = redir_mis_i;
`endif
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      src_q   <= SrcNone;
      addr_q  <= '0;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      valid_q <= valid_d;
      src_q   <= src_d;
      addr_q  <= addr_d;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
      mis_q   <= mis_d;
`endif
    end
  end

  assign pend_valid_o = valid_q;
  assign pend_trap_o  = valid_q && (src_q == SrcTrap);
  assign pend_addr_o  = addr_q;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
  assign pend_mis_o   = valid_q && mis_q;
`endif

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: boot vector, sequential step, jump/branch/trap redirects, hold and halt.
// Defining PC_SEQ_MISALIGN_TRAP_EN turns misaligned jump/branch targets into traps.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned     XLEN        = DefaultXlen,
  parameter int unsigned     INSTR_BYTES = DefaultInstrBytes,
  parameter logic [XLEN-1:0] RESET_VEC   = XLEN'(DefaultResetVec),
  parameter logic [XLEN-1:0] TRAP_VEC    = XLEN'(DefaultTrapVec)
) (
  input logic            clock,
  input logic            reset,
  pc_sequencer_if.master bus
);

  state_e          state_q, state_d;
  logic            halt_defer_q, halt_defer_d;
  redir_src_e      redir_src;
  logic [XLEN-1:0] redir_addr;
  logic            redir_valid, redir_is_trap;
  logic            in_run, fetch_req, fire, halt_now;
  logic            pend_valid, pend_trap;
  logic [XLEN-1:0] pend_addr;
  logic [XLEN-1:0] pc_next;
  logic            trap_taken;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
  logic            redir_mis, pend_mis, misalign;
`endif

  always_comb begin
    redir_src  = SrcNone;
    redir_addr = '0;
    if (bus.trap) begin
      redir_src  = SrcTrap;
      redir_addr = TRAP_VEC;
    end else if (bus.jump) begin
      redir_src  = SrcJump;
      redir_addr = bus.jump_target;
    end else if (bus.branch_taken) begin
      redir_src  = SrcBranch;
      redir_addr = bus.branch_target;
    end
`ifdef PC_SEQ_MISALIGN_TRAP_EN
    redir_mis = 1'b0;
    if ((redir_src != SrcNone) && (redir_src != SrcTrap) && is_misaligned(redir_addr[1:0]))
    begin
      redir_src  = SrcTrap;
      redir_addr = TRAP_VEC;
      redir_mis  = 1'b1;
    end
`endif
  end

  assign redir_valid   = redir_src != SrcNone;
  assign redir_is_trap = redir_src == SrcTrap;
  assign in_run        = state_q == StRun;
  assign fetch_req     = in_run && !bus.stall;
  assign fire          = fetch_req && bus.fetch_ready;
  // A trap in the halt cycle is latched first; the halt is taken one cycle later.
  assign halt_now      = in_run && (halt_defer_q || (bus.halt && !redir_is_trap));

  pc_redirect_buf #(
    .XLEN (XLEN)
  ) u_redirect_buf (
    .clock        (clock),
    .reset        (reset),
    .clear_i      (fire || halt_now),
    .capture_i    (in_run && !fire),
    .redir_src_i  (redir_src),
    .redir_addr_i (redir_addr),
`ifdef PC_SEQ_MISALIGN_TRAP_EN
    .redir_mis_i  (redir_mis),
    .pend_mis_o   (pend_mis),
`endif
    .pend_valid_o (pend_valid),
    .pend_trap_o  (pend_trap),
    .pend_addr_o  (pend_addr)
  );

  always_comb begin
    state_d      = state_q;
    halt_defer_d = 1'b0;
    case (state_q)
      StBoot: state_d = StRun;
      StRun: begin
        if (halt_now) state_d = StHalt;
        halt_defer_d = bus.halt && redir_is_trap && !halt_defer_q;
      end
      StHalt:  state_d = StHalt;
      default: state_d = StBoot;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StBoot;
      halt_defer_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      halt_defer_q <= halt_defer_d;
    end
  end

  always_comb begin
    pc_next    = bus.pc_cur;
    trap_taken = 1'b0;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
    misalign   = 1'b0;
`endif
    case (state_q)
      StBoot: pc_next = RESET_VEC;
      StRun: begin
        if (fire) begin
          if (pend_trap) begin
            pc_next    = TRAP_VEC;
            trap_taken = 1'b1;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
            misalign   = pend_mis;
`endif
          end else if (redir_valid) begin
            pc_next    = redir_addr;
            trap_taken = redir_is_trap;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
            misalign   = redir_mis;
`endif
          end else if (pend_valid) begin
            pc_next = pend_addr;
          end else begin
            pc_next = bus.pc_cur + XLEN'(INSTR_BYTES);
          end
        end
      end
      default: pc_next = bus.pc_cur;
    endcase
  end

  assign bus.pc_next          = pc_next;
  assign bus.fetch_req        = fetch_req;
  assign bus.redirect_pending = pend_valid;
  assign bus.halted           = state_q == StHalt;
  assign bus.trap_taken       = trap_taken;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
  assign bus.misalign         = misalign;
`endif

endmodule
